// File: rtl/rf_wr_arbiter_pkg.sv
// Shared widths and state encoding for the register-file write-port arbiter.
package rf_wr_arbiter_pkg;

    localparam int unsigned CPU_REGNO_WIDTH = 5;
    localparam int unsigned CPU_REG_WIDTH   = 32;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_FORCE = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rf_wr_arbiter.sv
// Register-file write-port arbiter: writeback has priority, MDU results fill free or stalled slots.
// Optional starvation guard (forced one-cycle stall) enabled by defining RF_WR_ARB_STARVE_EN.
module rf_wr_arbiter
    import rf_wr_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 8,
    parameter int unsigned CNT_WIDTH    = 4
) (
    input  logic                       clk,
    input  logic                       nrst,
    input  logic                       i_exec_stall,
    input  logic                       i_mem_stall,
    input  logic                       i_fetch_stall,
    input  logic [CPU_REGNO_WIDTH-1:0] i_wb_rd_no,
    input  logic [CPU_REG_WIDTH-1:0]   i_wb_rd_val,
    input  logic                       i_mdu_req,
    input  logic [CPU_REGNO_WIDTH-1:0] i_mdu_rd_no,
    input  logic [CPU_REG_WIDTH-1:0]   i_mdu_rd_val,
    output logic                       o_mdu_ack,
    output logic                       o_arb_stall,
    output logic [CPU_REGNO_WIDTH-1:0] o_rf_wr_no,
    output logic [CPU_REG_WIDTH-1:0]   o_rf_wr_val
);

    if (STARVE_LIMIT < 2 || STARVE_LIMIT > (2 ** CNT_WIDTH) - 1) begin : g_bad_limit
        $error("rf_wr_arbiter: STARVE_LIMIT out of range for CNT_WIDTH");
    end

    logic                       arb_stall_q;
    logic                       core_stall;
    logic                       grant;
    logic [CPU_REGNO_WIDTH-1:0] wr_no_q,  wr_no_d;
    logic [CPU_REG_WIDTH-1:0]   wr_val_q, wr_val_d;

    assign core_stall = i_exec_stall | i_mem_stall | i_fetch_stall | arb_stall_q;
    assign grant      = i_mdu_req & ((i_wb_rd_no == '0) | core_stall);

    assign o_mdu_ack   = grant;
    assign o_arb_stall = arb_stall_q;
    assign o_rf_wr_no  = wr_no_q;
    assign o_rf_wr_val = wr_val_q;

    // A stalled writeback stage re-presents its held value after release, so a
    // stalled slot can be handed to the MDU without losing writeback data.
    always_comb begin
        wr_no_d  = wr_no_q;
        wr_val_d = wr_val_q;
        if (grant) begin
            wr_no_d  = i_mdu_rd_no;
            wr_val_d = i_mdu_rd_val;
        end else if (!core_stall) begin
            wr_no_d  = i_wb_rd_no;
            wr_val_d = i_wb_rd_val;
        end else begin
            wr_no_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_no_q  <= '0;
            wr_val_q <= '0;
        end else begin
            wr_no_q  <= wr_no_d;
            wr_val_q <= wr_val_d;
        end
    end

`ifdef RF_WR_ARB_STARVE_EN
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STARVE_LIMIT - 1);

    arb_state_e           state_q, state_d;
    logic [CNT_WIDTH-1:0] wait_cnt_q, wait_cnt_d;
    logic                 arb_stall_d;

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        arb_stall_d = 1'b0;
        unique case (state_q)
            ARB_IDLE: begin
                if (i_mdu_req && !grant) begin
                    if (wait_cnt_q == CNT_LAST) begin
                        state_d     = ARB_FORCE;
                        arb_stall_d = 1'b1;
                    end else if (wait_cnt_q != '1) begin
                        wait_cnt_d = wait_cnt_q + CNT_WIDTH'(1);
                    end
                end else begin
                    wait_cnt_d = '0;
                end
            end
            // The forced stall guarantees the grant; a dropped req also lands back in IDLE.
            ARB_FORCE: begin
                state_d    = ARB_IDLE;
                wait_cnt_d = '0;
            end
            default: begin
                state_d    = ARB_IDLE;
                wait_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= ARB_IDLE;
            wait_cnt_q  <= '0;
            arb_stall_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            arb_stall_q <= arb_stall_d;
        end
    end
`else
    assign arb_stall_q = 1'b0;
`endif

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Self-checking bench for rf_wr_arbiter: directed scenarios plus randomized traffic
// against a cycle-level reference model of the arbitration rules.
module tb_rf_wr_arbiter;
    import rf_wr_arbiter_pkg::*;

    localparam int unsigned LIMIT = 8;

    logic                       clk = 1'b0;
    logic                       nrst;
    logic                       i_exec_stall, i_mem_stall, i_fetch_stall;
    logic [CPU_REGNO_WIDTH-1:0] i_wb_rd_no;
    logic [CPU_REG_WIDTH-1:0]   i_wb_rd_val;
    logic                       i_mdu_req;
    logic [CPU_REGNO_WIDTH-1:0] i_mdu_rd_no;
    logic [CPU_REG_WIDTH-1:0]   i_mdu_rd_val;
    logic                       o_mdu_ack, o_arb_stall;
    logic [CPU_REGNO_WIDTH-1:0] o_rf_wr_no;
    logic [CPU_REG_WIDTH-1:0]   o_rf_wr_val;

    rf_wr_arbiter #(
        .STARVE_LIMIT(LIMIT),
        .CNT_WIDTH   (4)
    ) dut (
        .clk          (clk),
        .nrst         (nrst),
        .i_exec_stall (i_exec_stall),
        .i_mem_stall  (i_mem_stall),
        .i_fetch_stall(i_fetch_stall),
        .i_wb_rd_no   (i_wb_rd_no),
        .i_wb_rd_val  (i_wb_rd_val),
        .i_mdu_req    (i_mdu_req),
        .i_mdu_rd_no  (i_mdu_rd_no),
        .i_mdu_rd_val (i_mdu_rd_val),
        .o_mdu_ack    (o_mdu_ack),
        .o_arb_stall  (o_arb_stall),
        .o_rf_wr_no   (o_rf_wr_no),
        .o_rf_wr_val  (o_rf_wr_val)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state: what the RF write port should show, and starvation bookkeeping.
    logic [CPU_REGNO_WIDTH-1:0] m_no;
    logic [CPU_REG_WIDTH-1:0]   m_val;
    bit                         m_forced;
    int                         m_wait;
    bit                         last_grant;
    int                         ack_count;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_no       = '0;
        m_val      = '0;
        m_forced   = 1'b0;
        m_wait     = 0;
        last_grant = 1'b0;
    endtask

    // One core cycle: entered just after a falling edge, returns at the next falling edge.
    task automatic step(input logic ex, input logic me, input logic fe,
                        input logic [CPU_REGNO_WIDTH-1:0] wno, input logic [CPU_REG_WIDTH-1:0] wval,
                        input logic rq, input logic [CPU_REGNO_WIDTH-1:0] mno,
                        input logic [CPU_REG_WIDTH-1:0] mval);
        bit stalled, g;
        i_exec_stall  = ex;
        i_mem_stall   = me;
        i_fetch_stall = fe;
        i_wb_rd_no    = wno;
        i_wb_rd_val   = wval;
        i_mdu_req     = rq;
        i_mdu_rd_no   = mno;
        i_mdu_rd_val  = mval;
        #1;
        stalled = ex || me || fe || m_forced;
        g = rq && (wno == 0 || stalled);
        chk("ack",       32'(o_mdu_ack),   32'(g));
        chk("arb_stall", 32'(o_arb_stall), 32'(m_forced));
        chk("wr_no",     32'(o_rf_wr_no),  32'(m_no));
        chk("wr_val",    o_rf_wr_val,      m_val);
        if (g) begin
            m_no  = mno;
            m_val = mval;
            ack_count++;
        end else if (!stalled) begin
            m_no  = wno;
            m_val = wval;
        end else begin
            m_no  = '0;
        end
`ifdef RF_WR_ARB_STARVE_EN
        if (m_forced) begin
            m_forced = 1'b0;
            m_wait   = 0;
        end else if (rq && !g) begin
            m_wait++;
            if (m_wait >= int'(LIMIT)) m_forced = 1'b1;
        end else begin
            m_wait = 0;
        end
`endif
        last_grant = g;
        @(negedge clk);
    endtask

    initial begin
        bit                         cur_req;
        logic [CPU_REGNO_WIDTH-1:0] cur_no;
        logic [CPU_REG_WIDTH-1:0]   cur_val;
        logic [CPU_REGNO_WIDTH-1:0] rwno;
        int                         acks_before;

        nrst = 1'b0;
        i_exec_stall = 1'b0; i_mem_stall = 1'b0; i_fetch_stall = 1'b0;
        i_wb_rd_no = '0; i_wb_rd_val = '0;
        i_mdu_req = 1'b0; i_mdu_rd_no = '0; i_mdu_rd_val = '0;
        ack_count = 0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_wr_no",     32'(o_rf_wr_no),  32'd0);
        chk("rst_wr_val",    o_rf_wr_val,      32'd0);
        chk("rst_arb_stall", 32'(o_arb_stall), 32'd0);
        nrst = 1'b1;

        // Free slot: MDU r3 granted immediately.
        step(0, 0, 0, 5'd0, 32'h0, 1, 5'd3, 32'h1234);
        chk("free_ack_seen", 32'(last_grant), 32'd1);
        chk("free_wr_no",    32'(o_rf_wr_no),  32'd3);
        chk("free_wr_val",   o_rf_wr_val,      32'h1234);

        // Busy slot: writeback r5 wins, MDU waits.
        step(0, 0, 0, 5'd5, 32'hAA, 1, 5'd6, 32'h6666);
        chk("busy_wr_no",  32'(o_rf_wr_no), 32'd5);
        chk("busy_wr_val", o_rf_wr_val,     32'hAA);
        step(0, 0, 0, 5'd0, 32'h0, 1, 5'd6, 32'h6666);

        // External stall: MDU r9 takes the stalled slot, held r7 follows after release.
        step(0, 1, 0, 5'd7, 32'h77, 1, 5'd9, 32'h99);
        chk("stall_wr_no",  32'(o_rf_wr_no), 32'd9);
        chk("stall_wr_val", o_rf_wr_val,     32'h99);
        step(0, 0, 0, 5'd7, 32'h77, 0, 5'd0, 32'h0);
        chk("release_wr_no",  32'(o_rf_wr_no), 32'd7);
        chk("release_wr_val", o_rf_wr_val,     32'h77);
        step(0, 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        chk("release_once", 32'(o_rf_wr_no), 32'd0);

        // Starvation: writeback busy every cycle with MDU r12 held.
        acks_before = ack_count;
        for (int i = 0; i < 50 && !last_grant; i++)
            step(0, 0, 0, 5'd5, 32'(i), 1, 5'd12, 32'hC0DE);
`ifdef RF_WR_ARB_STARVE_EN
        chk("starve_acks", 32'(ack_count - acks_before), 32'd1);
        chk("starve_wr_no", 32'(o_rf_wr_no), 32'd12);
        step(0, 0, 0, 5'd5, 32'h55, 0, 5'd0, 32'h0);
        chk("after_force_stall", 32'(o_arb_stall), 32'd0);
`else
        chk("nostarve_acks", 32'(ack_count - acks_before), 32'd0);
        step(0, 0, 0, 5'd0, 32'h0, 1, 5'd12, 32'hC0DE);
        chk("nostarve_free_ack", 32'(last_grant), 32'd1);
        chk("nostarve_wr_no",    32'(o_rf_wr_no), 32'd12);
`endif

        // Asynchronous reset mid-request.
        step(0, 0, 0, 5'd5, 32'h5A5A, 1, 5'd4, 32'h4444);
        nrst = 1'b0;
        #1;
        chk("async_rst_wr_no",  32'(o_rf_wr_no),  32'd0);
        chk("async_rst_wr_val", o_rf_wr_val,      32'd0);
        chk("async_rst_stall",  32'(o_arb_stall), 32'd0);
        chk("async_rst_ack",    32'(o_mdu_ack),   32'd0);
        model_reset();
        @(negedge clk);
        nrst = 1'b1;
        step(0, 0, 0, 5'd0, 32'h0, 1, 5'd4, 32'h4444);
        chk("post_rst_ack",   32'(last_grant), 32'd1);
        chk("post_rst_wr_no", 32'(o_rf_wr_no), 32'd4);

        // Randomized traffic honoring the MDU hold-until-ack protocol.
        cur_req = 1'b0; cur_no = '0; cur_val = '0;
        for (int i = 0; i < 600; i++) begin
            if (!cur_req || last_grant) begin
                cur_req = ($urandom_range(0, 2) != 0);
                cur_no  = 5'($urandom_range(1, 31));
                cur_val = $urandom;
            end
            rwno = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            step($urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
                 rwno, $urandom, cur_req, cur_no, cur_val);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
